// File: rtl/pipe_stage_buffer.sv
`default_nettype none
// ============================================================================
// pipe_stage_buffer : PC/instruction pipeline stage, skid or pass register
// Revision 1.0 : initial release
// ============================================================================
module pipe_stage_buffer #(
   parameter int              PC_W     = 32,
   parameter int              INSTR_W  = 32,
   parameter logic [PC_W-1:0] FLUSH_PC = 32'h0040_0000,
   parameter int              SKID     = 1,
   parameter int              CNT_W    = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               up_valid,
   output logic               up_ready,
   input  logic [PC_W-1:0]    up_pc,
   input  logic [INSTR_W-1:0] up_instr,
   output logic               dn_valid,
   input  logic               dn_ready,
   output logic [PC_W-1:0]    dn_pc,
   output logic [INSTR_W-1:0] dn_instr,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_cnt_max = '1;
   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   logic               r_dn_valid;
   logic [PC_W-1:0]    r_dn_pc;
   logic [INSTR_W-1:0] r_dn_instr;
   logic [CNT_W-1:0]   r_stall_cnt;
   logic [CNT_W-1:0]   r_flush_cnt;
   logic               w_up_xfer;
   logic               w_dn_xfer;

   assign w_dn_xfer = r_dn_valid & dn_ready;

   generate
      if (SKID != 0) begin : g_skid
         state_t             r_state;
         logic               r_up_ready;
         logic [PC_W-1:0]    r_skid_pc;
         logic [INSTR_W-1:0] r_skid_instr;

         assign w_up_xfer = up_valid & r_up_ready;
         assign up_ready  = r_up_ready;

         // up_ready is a register: it stays low through reset and rises on the first edge after.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_state      <= ST_EMPTY;
               r_up_ready   <= 1'b0;
               r_dn_valid   <= 1'b0;
               r_dn_pc      <= FLUSH_PC;
               r_dn_instr   <= '0;
               r_skid_pc    <= '0;
               r_skid_instr <= '0;
            end else if (flush) begin
               r_state      <= ST_EMPTY;
               r_up_ready   <= 1'b1;
               r_dn_valid   <= 1'b0;
               r_dn_pc      <= FLUSH_PC;
               r_dn_instr   <= '0;
               r_skid_pc    <= '0;
               r_skid_instr <= '0;
            end else begin
               r_up_ready <= 1'b1;
               case (r_state)
                  ST_EMPTY: begin
                     if (w_up_xfer) begin
                        r_dn_pc    <= up_pc;
                        r_dn_instr <= up_instr;
                        r_dn_valid <= 1'b1;
                        r_state    <= ST_ONE;
                     end
                  end
                  ST_ONE: begin
                     if (w_up_xfer && w_dn_xfer) begin
                        r_dn_pc    <= up_pc;
                        r_dn_instr <= up_instr;
                     end else if (w_dn_xfer) begin
                        r_dn_valid <= 1'b0;
                        r_state    <= ST_EMPTY;
                     end else if (w_up_xfer) begin
                        r_skid_pc    <= up_pc;
                        r_skid_instr <= up_instr;
                        r_up_ready   <= 1'b0;
                        r_state      <= ST_TWO;
                     end
                  end
                  ST_TWO: begin
                     if (w_dn_xfer) begin
                        r_dn_pc    <= r_skid_pc;
                        r_dn_instr <= r_skid_instr;
                        r_state    <= ST_ONE;
                     end else begin
                        r_up_ready <= 1'b0;
                     end
                  end
                  default: begin
                     r_state    <= ST_EMPTY;
                     r_dn_valid <= 1'b0;
                  end
               endcase
            end
         end
      end else begin : g_pass
         assign up_ready  = dn_ready | ~r_dn_valid;
         assign w_up_xfer = up_valid & up_ready;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_dn_valid <= 1'b0;
               r_dn_pc    <= FLUSH_PC;
               r_dn_instr <= '0;
            end else if (flush) begin
               r_dn_valid <= 1'b0;
               r_dn_pc    <= FLUSH_PC;
               r_dn_instr <= '0;
            end else if (w_up_xfer) begin
               r_dn_valid <= 1'b1;
               r_dn_pc    <= up_pc;
               r_dn_instr <= up_instr;
            end else if (w_dn_xfer) begin
               r_dn_valid <= 1'b0;
            end
         end
      end
   endgenerate

   // Statistics survive flush; only reset clears them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (r_dn_valid && !dn_ready && (r_stall_cnt != c_cnt_max))
            r_stall_cnt <= r_stall_cnt + c_cnt_one;
         if (flush && (r_flush_cnt != c_cnt_max))
            r_flush_cnt <= r_flush_cnt + c_cnt_one;
      end
   end

   assign dn_valid  = r_dn_valid;
   assign dn_pc     = r_dn_pc;
   assign dn_instr  = r_dn_instr;
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire
